// File: rtl/known_ch_table.sv
// known_ch_table: cluster-head table for the EER-RL node datapath.
// Stores up to CH_DEPTH announced cluster heads (ID, hops, Q-value) and
// continuously publishes the best one to routing / packet assembly.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   my_ID               this node's ID (records carrying it are dropped)
//   HB_reset/HB_CHlimit heartbeat: flush table, load per-round entry limit
//   en_KCH, fCH_*       one-cycle strobe presenting a CH record
//   chosenCH/hopsFromCH best cluster head and its hop count
//   ch_valid, ch_count  table non-empty flag, occupied entry count
//   busy, kch_drop      update in progress, record-rejected pulse
module known_ch_table #(
    parameter int WORD_WIDTH = 16,
    parameter int CH_DEPTH   = 8,
    localparam int IDX_W     = $clog2(CH_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WORD_WIDTH-1:0] my_ID,
    input  logic                  HB_reset,
    input  logic [WORD_WIDTH-1:0] HB_CHlimit,
    input  logic                  en_KCH,
    input  logic [WORD_WIDTH-1:0] fCH_ID,
    input  logic [WORD_WIDTH-1:0] fCH_Hops,
    input  logic [WORD_WIDTH-1:0] fCH_QValue,
    output logic [WORD_WIDTH-1:0] chosenCH,
    output logic [WORD_WIDTH-1:0] hopsFromCH,
    output logic                  ch_valid,
    output logic [IDX_W:0]        ch_count,
    output logic                  busy,
    output logic                  kch_drop
);

    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CH_DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(CH_DEPTH);

    typedef enum logic [1:0] {IDLE, LOOKUP, WRITE, SELECT} state_t;

    state_t state, nextState;

    logic [CH_DEPTH-1:0]   entValid;
    logic [WORD_WIDTH-1:0] idMem   [CH_DEPTH];
    logic [WORD_WIDTH-1:0] hopsMem [CH_DEPTH];
    logic [WORD_WIDTH-1:0] qMem    [CH_DEPTH];

    logic [CNT_W-1:0]      chLimit;
    logic [WORD_WIDTH-1:0] newId, newHops, newQ;
    logic [CNT_W-1:0]      scanIdx;
    logic [IDX_W-1:0]      curIdx;

    logic matchFound, freeFound, worstFound, bestFound;
    logic [IDX_W-1:0] matchIdx, freeIdx, worstIdx, bestIdx;

    logic ownId, hasRoom, beatsWorst, doWrite;
    logic curWorse, curBeatsBest;
    logic [CNT_W-1:0] limitIn;

    // Ranking: higher q, then fewer hops, then lower ID.
    function automatic logic beats(
        input logic [WORD_WIDTH-1:0] aId, aHops, aQ,
        input logic [WORD_WIDTH-1:0] bId, bHops, bQ
    );
        if (aQ != bQ) return aQ > bQ;
        if (aHops != bHops) return aHops < bHops;
        return aId < bId;
    endfunction

    assign curIdx = scanIdx[IDX_W-1:0];
    assign busy   = (state != IDLE);
    assign ownId  = (fCH_ID == my_ID);

    // 0 or an oversized limit both mean "whole table".
    assign limitIn = (HB_CHlimit == '0 ||
                      HB_CHlimit > WORD_WIDTH'(CH_DEPTH))
                   ? DEPTH_C : HB_CHlimit[CNT_W-1:0];

    assign hasRoom = (ch_count < chLimit);

    assign beatsWorst = beats(newId, newHops, newQ,
                              idMem[worstIdx], hopsMem[worstIdx],
                              qMem[worstIdx]);

    assign doWrite = matchFound || hasRoom ||
                     (worstFound && beatsWorst);

    assign curWorse = beats(idMem[worstIdx], hopsMem[worstIdx],
                            qMem[worstIdx], idMem[curIdx],
                            hopsMem[curIdx], qMem[curIdx]);

    assign curBeatsBest = beats(idMem[curIdx], hopsMem[curIdx],
                                qMem[curIdx], idMem[bestIdx],
                                hopsMem[bestIdx], qMem[bestIdx]);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nextState;
    end

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE:   if (en_KCH && !ownId) nextState = LOOKUP;
            LOOKUP: if (scanIdx == LAST_IDX) nextState = WRITE;
            WRITE:  nextState = doWrite ? SELECT : IDLE;
            SELECT: if (scanIdx == DEPTH_C) nextState = IDLE;
        endcase
        if (HB_reset) nextState = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            entValid   <= '0;
            ch_count   <= '0;
            chLimit    <= DEPTH_C;
            chosenCH   <= '0;
            hopsFromCH <= '1;
            ch_valid   <= 1'b0;
            kch_drop   <= 1'b0;
            newId      <= '0;
            newHops    <= '0;
            newQ       <= '0;
            scanIdx    <= '0;
            matchFound <= 1'b0;
            freeFound  <= 1'b0;
            worstFound <= 1'b0;
            bestFound  <= 1'b0;
            matchIdx   <= '0;
            freeIdx    <= '0;
            worstIdx   <= '0;
            bestIdx    <= '0;
        end else if (HB_reset) begin
            entValid   <= '0;
            ch_count   <= '0;
            chLimit    <= limitIn;
            chosenCH   <= '0;
            hopsFromCH <= '1;
            ch_valid   <= 1'b0;
            kch_drop   <= 1'b0;
        end else begin
            kch_drop <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (en_KCH) begin
                        if (ownId) begin
                            kch_drop <= 1'b1;
                        end else begin
                            newId      <= fCH_ID;
                            newHops    <= fCH_Hops;
                            newQ       <= fCH_QValue;
                            scanIdx    <= '0;
                            matchFound <= 1'b0;
                            freeFound  <= 1'b0;
                            worstFound <= 1'b0;
                        end
                    end
                end
                LOOKUP: begin
                    if (entValid[curIdx]) begin
                        if (!matchFound && idMem[curIdx] == newId) begin
                            matchFound <= 1'b1;
                            matchIdx   <= curIdx;
                        end
                        if (!worstFound || curWorse) begin
                            worstFound <= 1'b1;
                            worstIdx   <= curIdx;
                        end
                    end else if (!freeFound) begin
                        freeFound <= 1'b1;
                        freeIdx   <= curIdx;
                    end
                    scanIdx <= scanIdx + CNT_W'(1);
                end
                WRITE: begin
                    scanIdx   <= '0;
                    bestFound <= 1'b0;
                    if (matchFound) begin
                        hopsMem[matchIdx] <= newHops;
                        qMem[matchIdx]    <= newQ;
                    end else if (hasRoom) begin
                        entValid[freeIdx] <= 1'b1;
                        idMem[freeIdx]    <= newId;
                        hopsMem[freeIdx]  <= newHops;
                        qMem[freeIdx]     <= newQ;
                        ch_count          <= ch_count + CNT_W'(1);
                    end else if (worstFound && beatsWorst) begin
                        idMem[worstIdx]   <= newId;
                        hopsMem[worstIdx] <= newHops;
                        qMem[worstIdx]    <= newQ;
                    end else begin
                        kch_drop <= 1'b1;
                    end
                end
                SELECT: begin
                    // Extra step after the last index commits the result.
                    if (scanIdx == DEPTH_C) begin
                        if (bestFound) begin
                            chosenCH   <= idMem[bestIdx];
                            hopsFromCH <= hopsMem[bestIdx];
                            ch_valid   <= 1'b1;
                        end else begin
                            chosenCH   <= '0;
                            hopsFromCH <= '1;
                            ch_valid   <= 1'b0;
                        end
                    end else begin
                        if (entValid[curIdx] &&
                            (!bestFound || curBeatsBest)) begin
                            bestFound <= 1'b1;
                            bestIdx   <= curIdx;
                        end
                        scanIdx <= scanIdx + CNT_W'(1);
                    end
                end
            endcase
            if (en_KCH && state != IDLE) kch_drop <= 1'b1;
        end
    end

endmodule

// File: tb/tb_known_ch_table.sv
// tb_known_ch_table: scoreboard bench for known_ch_table.
// Stimulus queues expected drop/update events; a monitor pops and compares.
module tb_known_ch_table;

    localparam int D = 8;
    localparam int LAT_DONE = 2 * D + 3;
    localparam int LAT_FULL = D + 2;

    localparam int K_DONE = 0;
    localparam int K_OWN  = 1;
    localparam int K_FULL = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] my_ID;
    logic        HB_reset;
    logic [15:0] HB_CHlimit;
    logic        en_KCH;
    logic [15:0] fCH_ID, fCH_Hops, fCH_QValue;
    logic [15:0] chosenCH, hopsFromCH;
    logic        ch_valid;
    logic [3:0]  ch_count;
    logic        busy, kch_drop;

    typedef struct {
        int          cyc;
        logic        busy;
        logic [15:0] chosen;
        logic [15:0] hops;
        logic        valid;
        logic [3:0]  cnt;
    } exp_t;

    exp_t dropQ[$];
    exp_t doneQ[$];

    int cyc = 0;
    int nChecks = 0;
    int nErrors = 0;
    logic prevBusy = 1'b0;

    known_ch_table #(.WORD_WIDTH(16), .CH_DEPTH(D)) dut (
        .clk(clk), .rst(rst), .my_ID(my_ID),
        .HB_reset(HB_reset), .HB_CHlimit(HB_CHlimit),
        .en_KCH(en_KCH), .fCH_ID(fCH_ID), .fCH_Hops(fCH_Hops),
        .fCH_QValue(fCH_QValue), .chosenCH(chosenCH),
        .hopsFromCH(hopsFromCH), .ch_valid(ch_valid),
        .ch_count(ch_count), .busy(busy), .kch_drop(kch_drop)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        nChecks++;
        if (act != exp) begin
            nErrors++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Monitor: compares against the scoreboard on every DUT event.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (kch_drop) begin
                if (dropQ.size() == 0) begin
                    check("unexpected_drop", 1, 0);
                end else begin
                    e = dropQ.pop_front();
                    check("drop_cycle", cyc, e.cyc);
                    check("drop_busy", int'(busy), int'(e.busy));
                    check("drop_chosen", int'(chosenCH), int'(e.chosen));
                    check("drop_hops", int'(hopsFromCH), int'(e.hops));
                    check("drop_count", int'(ch_count), int'(e.cnt));
                end
            end else if (prevBusy && !busy) begin
                if (doneQ.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = doneQ.pop_front();
                    check("done_cycle", cyc, e.cyc);
                    check("done_chosen", int'(chosenCH), int'(e.chosen));
                    check("done_hops", int'(hopsFromCH), int'(e.hops));
                    check("done_valid", int'(ch_valid), int'(e.valid));
                    check("done_count", int'(ch_count), int'(e.cnt));
                end
            end
        end
        prevBusy = busy;
    end

    function automatic exp_t mk(input int c, input logic b,
                                input int ch, input int h,
                                input logic v, input int n);
        exp_t e;
        e.cyc = c; e.busy = b;
        e.chosen = 16'(ch); e.hops = 16'(h);
        e.valid = v; e.cnt = 4'(n);
        return e;
    endfunction

    // Present one record and queue what the DUT must answer with.
    task automatic sendRec(input int id, input int h, input int q,
                           input int kind, input int ch, input int eh,
                           input int n);
        @(negedge clk);
        en_KCH = 1'b1;
        fCH_ID = 16'(id); fCH_Hops = 16'(h); fCH_QValue = 16'(q);
        if (kind == K_DONE)
            doneQ.push_back(mk(cyc + LAT_DONE, 1'b0, ch, eh, 1'b1, n));
        else if (kind == K_OWN)
            dropQ.push_back(mk(cyc + 1, 1'b0, ch, eh, 1'b1, n));
        else
            dropQ.push_back(mk(cyc + LAT_FULL, 1'b0, ch, eh, 1'b1, n));
        @(negedge clk);
        en_KCH = 1'b0;
    endtask

    task automatic waitIdle();
        bit ok = 1'b0;
        for (int i = 0; i < 4 * D + 8; i++) begin
            @(negedge clk);
            if (!busy) begin ok = 1'b1; break; end
        end
        if (!ok) check("idle_timeout", 0, 1);
    endtask

    task automatic heartbeat(input int lim);
        @(negedge clk);
        HB_reset = 1'b1; HB_CHlimit = 16'(lim);
        @(negedge clk);
        HB_reset = 1'b0;
    endtask

    initial begin
        int base;
        rst = 1'b1; my_ID = 16'd99; HB_reset = 1'b0; HB_CHlimit = '0;
        en_KCH = 1'b0; fCH_ID = '0; fCH_Hops = '0; fCH_QValue = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_chosen", int'(chosenCH), 0);
        check("rst_hops", int'(hopsFromCH), 16'hFFFF);
        check("rst_valid", int'(ch_valid), 0);
        check("rst_count", int'(ch_count), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_drop", int'(kch_drop), 0);

        heartbeat(3);
        check("hb_chosen", int'(chosenCH), 0);
        check("hb_hops", int'(hopsFromCH), 16'hFFFF);
        check("hb_valid", int'(ch_valid), 0);
        check("hb_count", int'(ch_count), 0);

        // Ranking by Q-value, limit 3.
        sendRec(23, 2, 16'h3000, K_DONE, 23, 2, 1); waitIdle();
        sendRec(45, 2, 16'h2000, K_DONE, 23, 2, 2); waitIdle();
        sendRec(6, 1, 16'h4000, K_DONE, 6, 1, 3);   waitIdle();
        // Full table: too weak, then stronger than worst (45).
        sendRec(50, 3, 16'h1000, K_FULL, 6, 1, 3);  waitIdle();
        sendRec(51, 1, 16'h6000, K_DONE, 51, 1, 3); waitIdle();

        // Tie-break and refresh, limit 0 means whole table.
        heartbeat(0);
        check("hb2_valid", int'(ch_valid), 0);
        sendRec(6, 1, 16'h4000, K_DONE, 6, 1, 1);   waitIdle();
        sendRec(12, 1, 16'h4000, K_DONE, 6, 1, 2);  waitIdle();
        sendRec(6, 1, 16'h1000, K_DONE, 12, 1, 2);  waitIdle();
        sendRec(30, 3, 16'h4000, K_DONE, 12, 1, 3); waitIdle();

        // Own ID, changed only while idle.
        my_ID = 16'd12;
        sendRec(12, 0, 16'h7000, K_OWN, 12, 1, 3);
        check("own_busy", int'(busy), 0);
        waitIdle();

        // Heartbeat abort during SELECT.
        @(negedge clk);
        base = cyc;
        en_KCH = 1'b1;
        fCH_ID = 16'd40; fCH_Hops = 16'd2; fCH_QValue = 16'h5000;
        @(negedge clk);
        en_KCH = 1'b0;
        while (cyc < base + 12) @(negedge clk);
        HB_reset = 1'b1; HB_CHlimit = 16'd2;
        doneQ.push_back(mk(cyc + 1, 1'b0, 0, 16'hFFFF, 1'b0, 0));
        @(negedge clk);
        HB_reset = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_hops", int'(hopsFromCH), 16'hFFFF);

        // Back-pressure: record during busy is dropped and never stored.
        sendRec(7, 2, 16'h3000, K_DONE, 7, 2, 1);
        repeat (3) @(negedge clk);
        en_KCH = 1'b1;
        fCH_ID = 16'd8; fCH_Hops = 16'd1; fCH_QValue = 16'h7000;
        dropQ.push_back(mk(cyc + 1, 1'b1, 0, 16'hFFFF, 1'b0, 0));
        @(negedge clk);
        en_KCH = 1'b0;
        waitIdle();
        sendRec(9, 5, 16'h1000, K_DONE, 7, 2, 2);   waitIdle();
        sendRec(10, 1, 16'h0800, K_FULL, 7, 2, 2);  waitIdle();

        repeat (4) @(negedge clk);
        check("dropQ_empty", dropQ.size(), 0);
        check("doneQ_empty", doneQ.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 nChecks, nErrors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
